// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - forwarding select codes, result kinds, Tuse/Tnew constants and stage helpers
package fwd_pkg;

  localparam logic [2:0] SEL_REG   = 3'b000;
  localparam logic [2:0] SEL_ALU_M = 3'b001;
  localparam logic [2:0] SEL_WD    = 3'b010;
  localparam logic [2:0] SEL_PC8_E = 3'b011;
  localparam logic [2:0] SEL_PC8_M = 3'b100;
  localparam logic [2:0] SEL_PC8_W = 3'b101;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_DM  = 2'd1;
  localparam logic [1:0] SRC_PC8 = 2'd2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_PC8 = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_DM  = 2'd2;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [1:0] src;
  } prod_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    prod_t      prod;
    logic       md_start;
    logic       md_div;
  } stage_rec_t;

  function automatic logic hit(input prod_t p, input logic [4:0] addr);
    return (addr != 5'd0) && (p.dst == addr);
  endfunction

  function automatic prod_t age(input prod_t p);
    prod_t r;
    r = p;
    if (p.tnew != 2'd0) r.tnew = p.tnew - 2'd1;
    return r;
  endfunction

  // Only the newest matching stage decides; older stages are never a fallback.
  function automatic logic [2:0] fwd_sel(input logic use_e, input logic [4:0] addr,
                                         input prod_t e, input prod_t m, input prod_t w);
    if (use_e && hit(e, addr))
      return (e.tnew == TNEW_PC8 && e.src == SRC_PC8) ? SEL_PC8_E : SEL_REG;
    if (hit(m, addr)) begin
      if (m.tnew != 2'd0) return SEL_REG;
      case (m.src)
        SRC_ALU: return SEL_ALU_M;
        SRC_PC8: return SEL_PC8_M;
        default: return SEL_REG;
      endcase
    end
    if (hit(w, addr)) return (w.src == SRC_PC8) ? SEL_PC8_W : SEL_WD;
    return SEL_REG;
  endfunction

  function automatic logic src_stall(input logic [4:0] addr, input logic [1:0] tuse,
                                     input prod_t e, input prod_t m);
    return (tuse != TUSE_NONE) &&
           ((hit(e, addr) && e.tnew > tuse) || (hit(m, addr) && m.tnew > tuse));
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side hazard/forwarding bundle; stall_cnt present with STALL_STATS_EN
interface fwd_hazard_ctrl_if;
  logic [4:0]  rs_D, rt_D, dst_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic        md_start_D, md_div_D, md_use_D;
  logic        stall, md_busy;
  logic [2:0]  sel_rs_D, sel_rt_D, sel_rs_E, sel_rt_E, sel_rt_M;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, src_D,
    output md_start_D, md_div_D, md_use_D,
    input  stall, sel_rs_D, sel_rt_D, sel_rs_E, sel_rt_E, sel_rt_M, md_busy
`ifdef STALL_STATS_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, src_D,
    input  md_start_D, md_div_D, md_use_D,
    output stall, sel_rs_D, sel_rt_D, sel_rs_E, sel_rt_E, sel_rt_M, md_busy
`ifdef STALL_STATS_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/fwd_hazard_ctrl_md_busy_counter.sv
// rtl/fwd_hazard_ctrl_md_busy_counter.sv - mult/div busy timer, loaded when the op sits in E
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // A start while already counting simply reloads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (start)
      cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0) | start;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding select and stall control beside decode; STALL_STATS_EN adds stall_cnt
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_ctrl_if.slave bus
);

  stage_rec_t rec_d, rec_e, rec_m, rec_w;
  logic       busy, stall;
  logic       unused_w_bits;

  assign rec_d = '{rs: bus.rs_D, rt: bus.rt_D,
                   prod: '{dst: bus.dst_D, tnew: bus.tnew_D, src: bus.src_D},
                   md_start: bus.md_start_D, md_div: bus.md_div_D};

  assign stall = src_stall(bus.rs_D, bus.tuse_rs_D, rec_e.prod, rec_m.prod)
               | src_stall(bus.rt_D, bus.tuse_rt_D, rec_e.prod, rec_m.prod)
               | (bus.md_use_D & busy);

  // A stalled D instruction leaves a bubble in E rather than advancing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_e <= '0;
      rec_m <= '0;
      rec_w <= '0;
    end else begin
      rec_w <= rec_m;
      rec_m <= '{rs: rec_e.rs, rt: rec_e.rt, prod: age(rec_e.prod),
                 md_start: rec_e.md_start, md_div: rec_e.md_div};
      rec_e <= stall ? '0 : rec_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (rec_e.md_start),
    .is_div(rec_e.md_div),
    .busy  (busy)
  );

  assign bus.stall    = stall;
  assign bus.md_busy  = busy;
  assign bus.sel_rs_D = fwd_sel(1'b1, bus.rs_D, rec_e.prod, rec_m.prod, rec_w.prod);
  assign bus.sel_rt_D = fwd_sel(1'b1, bus.rt_D, rec_e.prod, rec_m.prod, rec_w.prod);
  assign bus.sel_rs_E = fwd_sel(1'b0, rec_e.rs, '0, rec_m.prod, rec_w.prod);
  assign bus.sel_rt_E = fwd_sel(1'b0, rec_e.rt, '0, rec_m.prod, rec_w.prod);
  assign bus.sel_rt_M = fwd_sel(1'b0, rec_m.rt, '0, '0, rec_w.prod);

  assign unused_w_bits = ^{rec_w.rs, rec_w.rt, rec_w.prod.tnew, rec_w.md_start, rec_w.md_div};

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (stall)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
  import fwd_pkg::*;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tur, tut;
    logic [4:0] dst;
    logic [1:0] tnew, src;
    logic       stall;
    logic [2:0] srd, strd, sre, ste, stm;
  } vec_t;

  localparam int NV = 35;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t tbl[NV];

  fwd_hazard_ctrl_if bus();

  fwd_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [4:0] rs, rt, input logic [1:0] tur, tut,
                             input logic [4:0] dst, input logic [1:0] tnew, src,
                             input logic stl, input logic [2:0] srd, strd, sre, ste, stm);
    vec_t r;
    r.rs = rs; r.rt = rt; r.tur = tur; r.tut = tut; r.dst = dst; r.tnew = tnew; r.src = src;
    r.stall = stl; r.srd = srd; r.strd = strd; r.sre = sre; r.ste = ste; r.stm = stm;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, rt, input logic [1:0] tur, tut,
                       input logic [4:0] dst, input logic [1:0] tnew, src,
                       input logic mds, mdd, mdu);
    bus.rs_D = rs; bus.rt_D = rt; bus.tuse_rs_D = tur; bus.tuse_rt_D = tut;
    bus.dst_D = dst; bus.tnew_D = tnew; bus.src_D = src;
    bus.md_start_D = mds; bus.md_div_D = mdd; bus.md_use_D = mdu;
  endtask

  task automatic drive_nop();
    drive(0, 0, TUSE_NONE, TUSE_NONE, 0, 0, SRC_ALU, 0, 0, 0);
  endtask

  task automatic check_all(input string tag, input logic stl, input logic [2:0] srd, strd,
                           sre, ste, stm, input logic bsy);
    check({tag, " stall"},    32'(bus.stall),    32'(stl));
    check({tag, " sel_rs_D"}, 32'(bus.sel_rs_D), 32'(srd));
    check({tag, " sel_rt_D"}, 32'(bus.sel_rt_D), 32'(strd));
    check({tag, " sel_rs_E"}, 32'(bus.sel_rs_E), 32'(sre));
    check({tag, " sel_rt_E"}, 32'(bus.sel_rt_E), 32'(ste));
    check({tag, " sel_rt_M"}, 32'(bus.sel_rt_M), 32'(stm));
    check({tag, " md_busy"},  32'(bus.md_busy),  32'(bsy));
  endtask

  task automatic md_seq(input string tag, input logic is_div, input int exp_cycles);
    int cnt;
    @(posedge clk); #1 drive(0, 0, 1, 1, 0, 0, SRC_ALU, 1, is_div, 1);
    @(negedge clk); check_all({tag, " issue"}, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, TUSE_NONE, TUSE_NONE, 10, TNEW_ALU, SRC_ALU, 0, 0, 1);
    @(negedge clk);
    cnt = 0;
    while (bus.stall && cnt < 40) begin
      check({tag, " busy during stall"}, 32'(bus.md_busy), 32'd1);
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    check({tag, " stall cycles"}, 32'(cnt), 32'(exp_cycles));
    check({tag, " busy at release"}, 32'(bus.md_busy), 32'd0);
    @(posedge clk); #1 drive_nop();
    @(posedge clk); @(posedge clk);
  endtask

  initial begin
    drive_nop();
    //           rs  rt  tur tut dst tnew src       | stl srd strd sre ste stm
    tbl[0]  = v(0,  0,  1,  1,  1,  1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1,  3,  1,  1,  2,  1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 1, 0, 0);
    tbl[3]  = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[4]  = v(0,  0,  1,  3,  1,  2,   SRC_DM,     0, 0, 0, 0, 0, 0);
    tbl[5]  = v(1,  0,  1,  1,  4,  1,   SRC_ALU,    1, 0, 0, 0, 0, 0);
    tbl[6]  = v(1,  0,  1,  1,  4,  1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[7]  = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 2, 0, 0);
    tbl[8]  = v(0,  0,  3,  3,  5,  2,   SRC_DM,     0, 0, 0, 0, 0, 0);
    tbl[9]  = v(5,  0,  0,  0,  0,  0,   SRC_ALU,    1, 0, 0, 0, 0, 0);
    tbl[10] = v(5,  0,  0,  0,  0,  0,   SRC_ALU,    1, 0, 0, 0, 0, 0);
    tbl[11] = v(5,  0,  0,  0,  0,  0,   SRC_ALU,    0, 2, 0, 0, 0, 0);
    tbl[12] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[13] = v(0,  0,  3,  3,  31, 0,   SRC_PC8,    0, 0, 0, 0, 0, 0);
    tbl[14] = v(31, 0,  0,  3,  0,  0,   SRC_ALU,    0, 3, 0, 0, 0, 0);
    tbl[15] = v(0,  31, 1,  1,  7,  1,   SRC_ALU,    0, 0, 4, 4, 0, 0);
    tbl[16] = v(31, 31, 1,  1,  6,  1,   SRC_ALU,    0, 5, 5, 0, 5, 0);
    tbl[17] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[18] = v(0,  0,  1,  1,  8,  1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[19] = v(0,  8,  1,  2,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[20] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 1, 0);
    tbl[21] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 2);
    tbl[22] = v(0,  0,  1,  1,  9,  1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[23] = v(0,  0,  1,  3,  9,  2,   SRC_DM,     0, 0, 0, 0, 0, 0);
    tbl[24] = v(0,  9,  3,  2,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[25] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[26] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 2);
    tbl[27] = v(0,  0,  3,  3,  0,  2,   SRC_DM,     0, 0, 0, 0, 0, 0);
    tbl[28] = v(0,  0,  0,  0,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[29] = v(0,  0,  3,  3,  10, 2,   SRC_DM,     0, 0, 0, 0, 0, 0);
    tbl[30] = v(0,  10, 3,  1,  11, 1,   SRC_ALU,    1, 0, 0, 0, 0, 0);
    tbl[31] = v(0,  10, 3,  1,  11, 1,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[32] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 2, 0);
    tbl[33] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);
    tbl[34] = v(0,  0,  3,  3,  0,  0,   SRC_ALU,    0, 0, 0, 0, 0, 0);

    #2 check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    #5 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 drive(tbl[i].rs, tbl[i].rt, tbl[i].tur, tbl[i].tut, tbl[i].dst, tbl[i].tnew,
               tbl[i].src, 0, 0, 0);
      @(negedge clk);
      check_all($sformatf("v%0d", i), tbl[i].stall, tbl[i].srd, tbl[i].strd,
                tbl[i].sre, tbl[i].ste, tbl[i].stm, 1'b0);
    end

    md_seq("div", 1'b1, 11);
    md_seq("mult", 1'b0, 6);

    // Reset while a load-use stall is active.
    @(posedge clk); #1 drive(0, 0, 1, 3, 1, TNEW_DM, SRC_DM, 0, 0, 0);
    @(posedge clk); #1 drive(1, 0, 1, 1, 4, TNEW_ALU, SRC_ALU, 0, 0, 0);
    @(negedge clk); check("pre-reset stall", 32'(bus.stall), 32'd1);
    #1 reset = 1'b0;
    #1 check_all("reset mid-stall", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk); check_all("after reset stall", 0, 0, 0, 0, 0, 0, 0);

    // Reset while the divider is busy.
    @(posedge clk); #1 drive(0, 0, 1, 1, 0, 0, SRC_ALU, 1, 1, 1);
    @(posedge clk); #1 drive(0, 0, TUSE_NONE, TUSE_NONE, 10, TNEW_ALU, SRC_ALU, 0, 0, 1);
    @(posedge clk); @(posedge clk);
    @(negedge clk); check("pre-reset busy", 32'(bus.md_busy), 32'd1);
    #1 reset = 1'b0;
    #1 check_all("reset mid-busy", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk); check_all("after reset busy", 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
